// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: captures a row of neuron spike pulses, timestamps each
// capture batch, serialises it into {neuron index, timestamp} AER words and
// buffers them in a first-word-fall-through FIFO behind valid/ready.
module spike_aer_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_WIDTH = 16,
  localparam int AW = $clog2(N_NEURONS),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_NEURONS-1:0]  spike_in,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [AW-1:0]         evt_addr,
  output logic [TS_WIDTH-1:0]   evt_ts,
  output logic [LW-1:0]         fifo_level,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(N_NEURONS + 1);
  localparam int SW = DROP_WIDTH + CW;
  localparam logic [N_NEURONS-1:0]  VEC_ONE = N_NEURONS'(1);
  localparam logic [DROP_WIDTH-1:0] DMAX    = '1;

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  // Scan state is implied by scan_vec: nothing left to emit means idle.
  typedef enum logic {S_IDLE, S_DRAIN} scan_st_e;

  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [N_NEURONS-1:0]  pend_vec, pend_vec_n;
  logic [TS_WIDTH-1:0]   pend_ts, pend_ts_n;
  logic [N_NEURONS-1:0]  scan_vec, scan_vec_n;
  logic [TS_WIDTH-1:0]   scan_ts, scan_ts_n;
  logic [DROP_WIDTH-1:0] drop_n;
  logic [N_NEURONS-1:0]  collide;
  logic [CW-1:0]         ncol;
  logic [SW-1:0]         drop_sum;
  logic [AW-1:0]         k;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  evt_t                  mem [FIFO_DEPTH];
  evt_t                  head;
  scan_st_e              scan_st;
  logic                  push, pop, scan_last, xfer;

  assign scan_st   = (scan_vec == '0) ? S_IDLE : S_DRAIN;
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign scan_last = (scan_st == S_DRAIN) && ((scan_vec & (scan_vec - VEC_ONE)) == '0);
  // No write-through when full: acceptance looks only at the current level.
  assign push      = (scan_st == S_DRAIN) && (fifo_level < LW'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign xfer      = (pend_vec != '0) && ((scan_st == S_IDLE) || (scan_last && push));

  // Lowest set bit of the scan vector is the next event to emit.
  always_comb begin
    k = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--)
      if (scan_vec[i]) k = AW'(i);
  end

  // Next state of pending/scan stages and the saturating drop counter.
  always_comb begin
    scan_vec_n = scan_vec;
    scan_ts_n  = scan_ts;
    pend_vec_n = pend_vec;
    pend_ts_n  = pend_ts;
    collide    = '0;
    ncol       = '0;
    case (scan_st)
      S_DRAIN: if (push) scan_vec_n = scan_vec & (scan_vec - VEC_ONE);
      default: ;
    endcase
    if (xfer) begin
      scan_vec_n = pend_vec;
      scan_ts_n  = pend_ts;
      pend_vec_n = spike_in;
      if (spike_in != '0) pend_ts_n = ts_cnt;
    end else begin
      pend_vec_n = pend_vec | spike_in;
      // Batch timestamp is the cycle of its first spike.
      if ((pend_vec == '0) && (spike_in != '0)) pend_ts_n = ts_cnt;
      collide = pend_vec & spike_in;
    end
    for (int i = 0; i < N_NEURONS; i++)
      ncol = ncol + CW'(collide[i]);
    drop_sum = SW'(drop_count) + SW'(ncol);
    drop_n   = (drop_sum > SW'(DMAX)) ? DMAX : drop_sum[DROP_WIDTH-1:0];
  end

  // Timestamp, stage registers, FIFO pointers/level and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt     <= '0;
      pend_vec   <= '0;
      pend_ts    <= '0;
      scan_vec   <= '0;
      scan_ts    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      ts_cnt     <= ts_cnt + TS_WIDTH'(1);
      pend_vec   <= pend_vec_n;
      pend_ts    <= pend_ts_n;
      scan_vec   <= scan_vec_n;
      scan_ts    <= scan_ts_n;
      drop_count <= drop_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  // Event storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= '{addr: k, ts: scan_ts};
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (fifo_level != '0);
  assign evt_addr  = evt_valid ? head.addr : '0;
  assign evt_ts    = evt_valid ? head.ts   : '0;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] spike_in;
  logic        evt_ready;
  logic        evt_valid, v4;
  logic [3:0]  evt_addr, a4;
  logic [15:0] evt_ts;
  logic [3:0]  ts4;
  logic [3:0]  fifo_level, lvl4;
  logic [15:0] drop_count, drop4;

  spike_aer_encoder dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_addr(evt_addr), .evt_ts(evt_ts),
    .fifo_level(fifo_level), .drop_count(drop_count));

  spike_aer_encoder #(.TS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .evt_valid(v4),
    .evt_ready(evt_ready), .evt_addr(a4), .evt_ts(ts4),
    .fifo_level(lvl4), .drop_count(drop4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending set, scan list of indices, event queue.
  typedef struct { int addr; int unsigned ts; } ev_t;
  bit [15:0]   m_pend;
  int unsigned m_ts, m_pts, m_sts;
  int          scanq[$];
  ev_t         fifo[$];
  int          m_drop;

  int          got_addr[$];
  int unsigned got_ts[$];
  int unsigned got_ts4[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [15:0] s, input logic r, input logic rdy);
    bit do_pop, do_push, do_xfer;
    ev_t e;
    int n;
    if (r) begin
      m_ts = 0; m_pend = 0; m_pts = 0; m_sts = 0; m_drop = 0;
      scanq.delete(); fifo.delete();
      return;
    end
    do_pop  = (fifo.size() != 0) && rdy;
    do_push = (scanq.size() != 0) && (fifo.size() < 8);
    do_xfer = (m_pend != 0) && ((scanq.size() == 0) || (scanq.size() == 1 && do_push));
    if (do_pop) void'(fifo.pop_front());
    if (do_push) begin
      e.addr = scanq.pop_front();
      e.ts   = m_sts;
      fifo.push_back(e);
    end
    if (do_xfer) begin
      for (int i = 0; i < 16; i++) if (m_pend[i]) scanq.push_back(i);
      m_sts  = m_pts;
      m_pend = s;
      if (s != 0) m_pts = m_ts;
    end else begin
      n = $countones(m_pend & s);
      m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
      if (m_pend == 0 && s != 0) m_pts = m_ts;
      m_pend |= s;
    end
    m_ts++;
  endtask

  // One clock: drive, record pops, step model, then compare after the edge.
  task automatic cyc(input logic [15:0] s, input logic r, input logic rdy);
    spike_in = s; rst = r; evt_ready = rdy;
    if (rdy && evt_valid === 1'b1) begin
      got_addr.push_back(int'(evt_addr));
      got_ts.push_back(int'(evt_ts));
    end
    if (rdy && v4 === 1'b1) got_ts4.push_back(int'(ts4));
    @(posedge clk);
    model_step(s, r, rdy);
    #1;
    chk("m_valid", evt_valid, fifo.size() != 0);
    chk("m_level", fifo_level, fifo.size());
    chk("m_drop", drop_count, m_drop);
    chk("m4_valid", v4, fifo.size() != 0);
    chk("m4_level", lvl4, fifo.size());
    chk("m4_drop", drop4, m_drop);
    if (fifo.size() != 0) begin
      chk("m_addr", evt_addr, fifo[0].addr);
      chk("m_ts", evt_ts, fifo[0].ts & 32'hFFFF);
      chk("m4_addr", a4, fifo[0].addr);
      chk("m4_ts", ts4, fifo[0].ts & 32'hF);
    end
  endtask

  typedef struct {
    logic [15:0] spk;
    logic        rdy;
    logic        v;
    logic [3:0]  a;
    logic [15:0] t;
    logic [3:0]  lvl;
  } vec_t;
  vec_t tbl[17];

  task automatic drain_check(input string nm, input int exp_addr[$], input int cycles);
    got_addr.delete(); got_ts.delete(); got_ts4.delete();
    repeat (cycles) cyc(16'h0, 1'b0, 1'b1);
    chk({nm, "_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      chk({nm, "_addr"}, got_addr[i], exp_addr[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    int pr;
    logic [15:0] s;
    spike_in = '0; rst = 1'b1; evt_ready = 1'b0;

    // Reset state
    cyc(16'h0, 1'b1, 1'b1);
    cyc(16'h0, 1'b1, 1'b1);
    chk("rst_valid", evt_valid, 0);
    chk("rst_addr", evt_addr, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);

    // Single spike (ts 5) and a three-spike batch (ts 10)
    for (int i = 0; i < 17; i++) tbl[i] = '{16'h0, 1'b1, 1'b0, 4'h0, 16'h0, 4'h0};
    tbl[5].spk  = 16'h0010;
    tbl[7]      = '{16'h0, 1'b1, 1'b1, 4'd4,  16'd5,  4'd1};
    tbl[10].spk = 16'h8101;
    tbl[12]     = '{16'h0, 1'b1, 1'b1, 4'd0,  16'd10, 4'd1};
    tbl[13]     = '{16'h0, 1'b1, 1'b1, 4'd8,  16'd10, 4'd1};
    tbl[14]     = '{16'h0, 1'b1, 1'b1, 4'd15, 16'd10, 4'd1};
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].spk, 1'b0, tbl[i].rdy);
      chk("tbl_valid", evt_valid, tbl[i].v);
      chk("tbl_level", fifo_level, tbl[i].lvl);
      if (tbl[i].v) begin
        chk("tbl_addr", evt_addr, tbl[i].a);
        chk("tbl_ts", evt_ts, tbl[i].t);
      end
    end

    // Back-pressure: ten spikes, FIFO fills to 8, head stays put
    cyc(16'h0, 1'b1, 1'b0);
    cyc(16'h03FF, 1'b0, 1'b0);
    repeat (12) cyc(16'h0, 1'b0, 1'b0);
    chk("bp_level", fifo_level, 8);
    chk("bp_head", evt_addr, 0);
    chk("bp_ts", evt_ts, 0);
    repeat (3) cyc(16'h0, 1'b0, 1'b0);
    chk("bp_head_hold", evt_addr, 0);
    chk("bp_ts_hold", evt_ts, 0);
    chk("bp_valid_hold", evt_valid, 1);
    exp_q = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    drain_check("bp", exp_q, 20);
    chk("bp_drop", drop_count, 0);

    // Collision: FIFO full, scan stuck on neuron 8, neuron 3 spikes twice
    cyc(16'h0, 1'b1, 1'b0);
    cyc(16'h00FF, 1'b0, 1'b0);
    repeat (12) cyc(16'h0, 1'b0, 1'b0);
    cyc(16'h0100, 1'b0, 1'b0);
    cyc(16'h0, 1'b0, 1'b0);
    cyc(16'h0008, 1'b0, 1'b0);
    chk("col_drop0", drop_count, 0);
    cyc(16'h0008, 1'b0, 1'b0);
    chk("col_drop1", drop_count, 1);
    repeat (3) cyc(16'h0, 1'b0, 1'b0);
    chk("col_drop_hold", drop_count, 1);
    exp_q = {0, 1, 2, 3, 4, 5, 6, 7, 8, 3};
    drain_check("col", exp_q, 20);

    // Reset mid-drain: level 5, scan still holding five bits, drop_count 1
    cyc(16'h03FF, 1'b0, 1'b0);
    repeat (6) cyc(16'h0, 1'b0, 1'b0);
    chk("mid_level", fifo_level, 5);
    chk("mid_drop", drop_count, 1);
    cyc(16'hFFFF, 1'b1, 1'b0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_drop", drop_count, 0);
    exp_q = {};
    drain_check("mid_stale", exp_q, 12);

    // Timestamp wrap on the 4-bit instance: ts 15 then ts 17 (shows as 1)
    cyc(16'h0, 1'b1, 1'b1);
    repeat (15) cyc(16'h0, 1'b0, 1'b1);
    cyc(16'h0001, 1'b0, 1'b1);
    cyc(16'h0, 1'b0, 1'b1);
    cyc(16'h0002, 1'b0, 1'b1);
    got_addr.delete(); got_ts.delete(); got_ts4.delete();
    repeat (10) cyc(16'h0, 1'b0, 1'b1);
    chk("wrap_count", got_ts4.size(), 2);
    if (got_ts4.size() == 2) begin
      chk("wrap_ts_a", got_ts4[0], 15);
      chk("wrap_ts_b", got_ts4[1], 1);
    end
    if (got_ts.size() == 2) chk("wrap_wide_ts_b", got_ts[1], 17);

    // Randomized run against the model
    cyc(16'h0, 1'b1, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      pr = (c / 250) % 3;
      s = '0;
      for (int b = 0; b < 16; b++)
        if ($urandom_range(0, (c / 500) % 2 == 0 ? 15 : 3) == 0) s[b] = 1'b1;
      cyc(s, ($urandom_range(0, 999) == 0),
          ($urandom_range(0, 9) < (pr == 0 ? 9 : (pr == 1 ? 5 : 1))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream collector for a row of `lif_neuron` instances. It samples their single-cycle `spike` outputs as a parallel vector and timestamps each capture batch. It then serialises the batch into Address-Event Representation (AER) words (neuron index plus timestamp) and buffers them in a FIFO behind a valid/ready handshake toward the router or host interface.

## Interface
- `N_NEURONS`, default 16: width of the spike vector, range 2..64. Define `AW = $clog2(N_NEURONS)`.
- `TS_WIDTH`, default 16: width of the timestamp counter and of `evt_ts`.
- `FIFO_DEPTH`, default 8: event FIFO entries. Must be a power of two, ≥2.
- `DROP_WIDTH`, default 16: width of the drop counter.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `spike_in`  in  N_NEURONS: bit i is the `spike` output of neuron i, sampled every cycle.
- `evt_valid`  out  1: FIFO head is valid.
- `evt_ready`  in  1: consumer accepts the head.
- `evt_addr`  out  AW: neuron index of the head event.
- `evt_ts`  out  TS_WIDTH: capture timestamp of the head event.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `drop_count`  out  DROP_WIDTH: saturating count of dropped spikes.

## Operation
- **ts_cnt.** Free-running TS_WIDTH counter. Resets to 0, increments by 1 every cycle, wraps from 2^TS_WIDTH−1 to 0.
- **Pending stage** (`pend_vec`, `pend_ts`). Behaviour depends on whether pending transfers to scan this edge.
  - Transfer this edge: `pend_vec <= spike_in`. If `spike_in != 0`, `pend_ts <= ts_cnt`.
  - No transfer: `pend_vec <= pend_vec | spike_in`.
    - If `pend_vec == 0` and `spike_in != 0`: `pend_ts <= ts_cnt`.
    - Otherwise `pend_ts` holds. The batch timestamp is the cycle of the batch's first spike.
  - Collision: a `spike_in` bit set while the same `pend_vec` bit is set and no transfer occurs. The spike is dropped. `drop_count` increases by the number of colliding bits that cycle, saturating at all-ones.
- **Scan stage** (`scan_vec`, `scan_ts`).
  - Two states, derived from `scan_vec`: IDLE (`scan_vec == 0`) and DRAIN.
  - Transfer pending to scan when `pend_vec != 0` and either condition holds:
    - scan is IDLE, or
    - scan is in DRAIN with exactly one bit left, and that bit is pushed this edge.
  - DRAIN: the lowest set bit index k of `scan_vec` is the candidate. If the FIFO accepts the push, `{k, scan_ts}` is written and bit k is cleared.
  - If the FIFO does not accept, scan holds. Back-pressure then accumulates in pending, and further repeats from the same neuron are dropped.
- **FIFO.**
  - A push is accepted iff `fifo_level < FIFO_DEPTH`. There is no write-through when full, even if a pop occurs the same edge.
  - Pop when `evt_valid && evt_ready`.
  - Simultaneous push and pop leaves the level unchanged.
  - First-word-fall-through: `evt_addr`/`evt_ts` show the head whenever `evt_valid = 1`. Read and write pointers wrap modulo FIFO_DEPTH.
- **Handshake.**
  - While `evt_valid = 1` and `evt_ready = 0`, `evt_addr`/`evt_ts` hold stable.
  - `evt_valid` never drops without a pop.
- **Reset.** At any time, including mid-drain, reset clears ts_cnt, pend_vec, pend_ts, scan_vec, scan_ts, FIFO pointers, fifo_level and drop_count. Buffered events are discarded.

## Timing
- Reset values: `evt_valid = 0`, `evt_addr = 0`, `evt_ts = 0`, `fifo_level = 0`, `drop_count = 0`.
- `spike_in` is ignored in the cycle `rst` is high.
- Latency, with `spike_in` high in cycle t, an empty pipeline and the FIFO not full:
  - pending loaded at edge t+1;
  - scan loaded at edge t+2;
  - FIFO pushed at edge t+3;
  - `evt_valid = 1` in cycle t+3, with `evt_ts = ts_cnt` value of cycle t.
- Throughput: at most one event pushed per cycle. A batch of m spikes occupies scan for m cycles.
- Ordering:
  - Within a batch, ascending neuron index.
  - Across batches, capture order.
  - Timestamps are non-decreasing modulo wrap.
- All outputs are registered or driven directly from registers and FIFO storage. There is no combinational path from `spike_in` to any output.
- `evt_ready` affects only the pop in the same edge; there is no combinational path to `evt_valid`.

## Test plan
- **Single spike.** Reset. `spike_in = 16'h0010` in cycle 5 (ts 5), `evt_ready = 1` → exactly one event `evt_addr = 4`, `evt_ts = 5`, `evt_valid` high in cycle 8 only.
- **Batch ordering.** `spike_in = 16'h8101` in one cycle (ts 10) → three events on consecutive cycles, addr 0, 8, 15, all with `evt_ts = 10`.
- **Back-pressure and full.**
  - Setup: `evt_ready = 0`; spikes on neurons 0..9 in a single cycle.
  - Expected: `fifo_level` saturates at 8 with addr 0..7 stored. Scan holds bits 8 and 9. Head stays addr 0 with stable `evt_ts`.
  - Then raise `evt_ready` → all 10 events emerge in order, no loss, `drop_count = 0`.
- **Collision drop.**
  - Setup: FIFO held full (`evt_ready = 0`). Neuron 3 spikes in two cycles while its pending bit is still set.
  - Expected: `drop_count = 1`. Only one neuron-3 event is later delivered.
- **Timestamp wrap.** TS_WIDTH = 4. Spike at ts 15 and a second spike two cycles later → events carry `evt_ts = 15`, then `evt_ts = 1`.
- **Reset mid-operation.** Assert `rst` for one cycle while `fifo_level = 5` and scan is in DRAIN → next cycle `evt_valid = 0`, `fifo_level = 0`, `drop_count = 0`; no stale events afterward.
